// File: rtl/hitchhike_pkg.sv
// rtl/hitchhike_pkg.sv - shared constants and state encoding for the hitchhike tag link
package hitchhike_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    // Both tag modulator and decoder must agree on the chip repetition.
    localparam int          REP_FACTOR_DEFAULT = 4;
    localparam int          SYNC_LEN_DEFAULT   = 16;
    localparam logic [15:0] SYNC_WORD_DEFAULT  = 16'hA5C3;

endpackage

// File: rtl/chip_majority_vote.sv
// rtl/chip_majority_vote.sv - folds REP_FACTOR tag chips into one majority-voted bit
module chip_majority_vote #(
    parameter int REP_FACTOR = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic in_valid,
    input  logic chip,
    output logic bit_valid,
    output logic data_bit
);

    localparam int PW = $clog2(REP_FACTOR);
    localparam int OW = PW + 1;

    logic [PW-1:0] phase;
    logic [OW-1:0] ones;
    logic [OW-1:0] total;

    // The decision includes the chip arriving this cycle so the bit is ready without extra latency.
    always_comb begin
        total     = ones + OW'(chip);
        bit_valid = in_valid && (phase == PW'(REP_FACTOR - 1));
        data_bit  = bit_valid && (total > OW'(REP_FACTOR / 2));
    end

    // Chip-phase and ones accumulation; both restart after each decided bit.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            phase <= '0;
            ones  <= '0;
        end else if (in_valid) begin
            if (bit_valid) begin
                phase <= '0;
                ones  <= '0;
            end else begin
                phase <= phase + 1'b1;
                ones  <= total;
            end
        end
    end

endmodule

// File: rtl/hitchhike_tag_decoder.sv
// rtl/hitchhike_tag_decoder.sv - sync hunt, length/payload framing and byte output for tag frames
module hitchhike_tag_decoder
    import hitchhike_pkg::*;
#(
    parameter int                  REP_FACTOR = REP_FACTOR_DEFAULT,
    parameter int                  SYNC_LEN   = SYNC_LEN_DEFAULT,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       orig_bit,
    input  logic       bs_bit,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_start,
    output logic       frame_end,
    output logic       sync_lock,
    output logic       overflow_err
);

    localparam int CW = SYNC_LEN * REP_FACTOR;

    function automatic logic [CW-1:0] expand_sync(input logic [SYNC_LEN-1:0] w);
        logic [CW-1:0] r;
        for (int i = 0; i < CW; i++) begin
            r[i] = w[i / REP_FACTOR];
        end
        return r;
    endfunction

    localparam logic [CW-1:0] SYNC_CHIPS = expand_sync(SYNC_WORD);

    state_t        state;
    logic [CW-1:0] chip_sr;
    logic [CW-1:0] chip_next;
    logic          chip;
    logic          sync_hit;
    logic          vote_valid;
    logic          bit_valid;
    logic          data_bit;
    logic [2:0]    bit_cnt;
    logic [7:0]    byte_sr;
    logic [7:0]    full_byte;
    logic          byte_done;
    logic [7:0]    remaining;

    // Tag chip recovery and the sync comparison against the newest chip window.
    always_comb begin
        chip       = orig_bit ^ bs_bit;
        chip_next  = {chip_sr[CW-2:0], chip};
        sync_hit   = (state == ST_HUNT) && in_valid && (chip_next == SYNC_CHIPS);
        vote_valid = in_valid && (state != ST_HUNT);
        full_byte  = {byte_sr[6:0], data_bit};
        byte_done  = bit_valid && (bit_cnt == 3'd7);
    end

    chip_majority_vote #(
        .REP_FACTOR(REP_FACTOR)
    ) u_vote (
        .clock    (clock),
        .reset    (reset),
        .clear    (sync_hit),
        .in_valid (vote_valid),
        .chip     (chip),
        .bit_valid(bit_valid),
        .data_bit (data_bit)
    );

    // Frame FSM with byte assembly and the held output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_HUNT;
            chip_sr      <= '0;
            bit_cnt      <= '0;
            byte_sr      <= '0;
            remaining    <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            sync_lock    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            overflow_err <= 1'b0;
            // Lock is held through the frame_end cycle and dropped right after.
            if (frame_end) sync_lock <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;

            case (state)
                ST_HUNT: begin
                    if (sync_hit) begin
                        frame_start <= 1'b1;
                        sync_lock   <= 1'b1;
                        bit_cnt     <= '0;
                        state       <= ST_LEN;
                    end else if (in_valid) begin
                        chip_sr <= chip_next;
                    end
                end
                ST_LEN: begin
                    if (bit_valid) begin
                        byte_sr <= full_byte;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (byte_done) begin
                            if (full_byte == 8'd0) begin
                                sync_lock <= 1'b0;
                                chip_sr   <= '0;
                                state     <= ST_HUNT;
                            end else begin
                                remaining <= full_byte;
                                state     <= ST_PAYLOAD;
                            end
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (bit_valid) begin
                        byte_sr <= full_byte;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (byte_done) begin
                            // A still-unaccepted byte wins; the new one is dropped but still counted.
                            if (out_valid && !out_ready) begin
                                overflow_err <= 1'b1;
                            end else begin
                                out_data  <= full_byte;
                                out_valid <= 1'b1;
                            end
                            remaining <= remaining - 1'b1;
                            if (remaining == 8'd1) begin
                                frame_end <= 1'b1;
                                chip_sr   <= '0;
                                state     <= ST_HUNT;
                            end
                        end
                    end
                end
                default: state <= ST_HUNT;
            endcase
        end
    end

endmodule
